// File: rtl/issue_queue.sv
// Collapsing issue queue between dispatch and register-read, with wakeup.
// Ports: clk/rst, flush, enq_* (dispatch side), wb_* (wakeup), issue_* (RR side), count.
package iqt;
  typedef enum logic [0:0] {
    IQ_ALU = 1'b0,
    IQ_MEM = 1'b1
  } queue_type_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic        has_rd;
    logic [4:0]  rd;
    logic        has_rs1;
    logic [4:0]  rs1;
    logic        has_rs2;
    logic [4:0]  rs2;
  } queue_item_t;
endpackage

module issue_queue
  import iqt::*;
#(
  parameter int DEPTH    = 8,
  parameter int NUM_WB   = 2,
  parameter int IN_ORDER = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  queue_item_t                enq_item,
  input  logic                       enq_rs1_busy,
  input  logic                       enq_rs2_busy,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*5-1:0]        wb_rd,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output queue_item_t                issue_item,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] r1;
  logic [DEPTH-1:0] r2;
  queue_item_t      item [DEPTH];
  logic [CW-1:0]    cnt;

  logic [DEPTH-1:0] rdy_vec;
  logic [DEPTH-1:0] u1;
  logic [DEPTH-1:0] u2;
  logic [DEPTH-1:0] n_valid;
  logic [DEPTH-1:0] n_r1;
  logic [DEPTH-1:0] n_r2;
  queue_item_t      n_item [DEPTH];

  logic          found;
  logic [IW-1:0] sel;
  logic          issue_fire;
  logic          enq_fire;
  logic          e1;
  logic          e2;
  logic [CW-1:0] wpos;

  // x0 never matches, so it can neither wake nor block an entry.
  function automatic logic wake_hit(input logic [4:0] r);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && wb_rd[5*k +: 5] == r && r != 5'd0) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  assign count     = cnt;
  assign enq_ready = cnt < CW'(DEPTH);
  assign rdy_vec   = valid & r1 & r2;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    if (IN_ORDER != 0) begin
      found = rdy_vec[0];
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (rdy_vec[i]) begin
          found = 1'b1;
          sel   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    issue_item = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (found && sel == IW'(i)) begin
        issue_item = item[i];
      end
    end
  end

  assign issue_valid = found;
  assign issue_fire  = found && issue_ready;
  assign enq_fire    = enq_valid && enq_ready && !flush;
  assign wpos        = cnt - CW'(issue_fire);

  assign e1 = !enq_item.has_rs1 || enq_item.rs1 == 5'd0 ||
              !enq_rs1_busy || wake_hit(enq_item.rs1);
  assign e2 = !enq_item.has_rs2 || enq_item.rs2 == 5'd0 ||
              !enq_rs2_busy || wake_hit(enq_item.rs2);

  // Readiness including this cycle's broadcasts; travels with shifting slots.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      u1[i] = r1[i] | wake_hit(item[i].rs1);
      u2[i] = r2[i] | wake_hit(item[i].rs2);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      n_valid[i] = valid[i];
      n_item[i]  = item[i];
      n_r1[i]    = u1[i];
      n_r2[i]    = u2[i];
    end
    if (issue_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= sel) begin
          n_valid[i] = valid[i+1];
          n_item[i]  = item[i+1];
          n_r1[i]    = u1[i+1];
          n_r2[i]    = u2[i+1];
        end
      end
      n_valid[DEPTH-1] = 1'b0;
    end
    if (enq_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wpos) begin
          n_valid[i] = 1'b1;
          n_item[i]  = enq_item;
          n_r1[i]    = e1;
          n_r2[i]    = e2;
        end
      end
    end
    if (flush) begin
      n_valid = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      r1    <= '0;
      r2    <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        item[i] <= '0;
      end
    end else begin
      valid <= n_valid;
      r1    <= n_r1;
      r2    <= n_r2;
      for (int i = 0; i < DEPTH; i++) begin
        item[i] <= n_item[i];
      end
      if (flush) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(enq_fire) - CW'(issue_fire);
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: dut0 is out-of-order, dut1 in-order.
// Both share stimulus; each task checks the instance it targets.
module tb_issue_queue;
  import iqt::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  queue_item_t enq_item;
  logic        enq_rs1_busy;
  logic        enq_rs2_busy;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic        issue_ready;

  logic        er0, iv0, er1, iv1;
  queue_item_t ii0, ii1;
  logic [3:0]  cnt0, cnt1;

  int passed;
  int total;

  issue_queue #(.DEPTH(8), .NUM_WB(2), .IN_ORDER(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(er0), .enq_item(enq_item),
    .enq_rs1_busy(enq_rs1_busy), .enq_rs2_busy(enq_rs2_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_valid(iv0), .issue_ready(issue_ready),
    .issue_item(ii0), .count(cnt0)
  );

  issue_queue #(.DEPTH(8), .NUM_WB(2), .IN_ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(er1), .enq_item(enq_item),
    .enq_rs1_busy(enq_rs1_busy), .enq_rs2_busy(enq_rs2_busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_valid(iv1), .issue_ready(issue_ready),
    .issue_item(ii1), .count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic queue_item_t mk(input logic [31:0] pc,
                                     input logic h1, input logic [4:0] s1,
                                     input logic h2, input logic [4:0] s2);
    queue_item_t t;
    t = '0;
    t.pc = pc;
    t.has_rd = 1'b1;
    t.rd = pc[4:0];
    t.has_rs1 = h1;
    t.rs1 = s1;
    t.has_rs2 = h2;
    t.rs2 = s2;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0;
    enq_valid = 0;
    enq_item = '0;
    enq_rs1_busy = 0;
    enq_rs2_busy = 0;
    wb_valid = '0;
    wb_rd = '0;
    issue_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic enq(input queue_item_t t, input logic b1, input logic b2);
    enq_valid = 1;
    enq_item = t;
    enq_rs1_busy = b1;
    enq_rs2_busy = b2;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    total++; if (cnt0 !== 4'd0) $display("FAIL reset_count got %0d exp 0", cnt0); else passed++;
    total++; if (iv0 !== 1'b0) $display("FAIL reset_issue_valid got %b exp 0", iv0); else passed++;
    total++; if (ii0 !== '0) $display("FAIL reset_issue_item got %h exp 0", ii0); else passed++;
    total++; if (er0 !== 1'b1) $display("FAIL reset_enq_ready got %b exp 1", er0); else passed++;
    step();
    rst = 0;
  endtask

  task automatic test_basic();
    queue_item_t a, b, c;
    a = mk(32'h100, 1, 5'd1, 1, 5'd2);
    b = mk(32'h104, 0, 5'd0, 0, 5'd0);
    c = mk(32'h108, 1, 5'd3, 0, 5'd0);
    do_reset();
    enq(a, 0, 0);
    step();
    total++; if (cnt0 !== 4'd1) $display("FAIL basic_cnt1 got %0d exp 1", cnt0); else passed++;
    total++; if (iv0 !== 1'b1 || ii0 !== a) $display("FAIL basic_issue_a got %b/%h exp 1/%h", iv0, ii0, a); else passed++;
    enq(b, 0, 0);
    step();
    total++; if (cnt0 !== 4'd2) $display("FAIL basic_cnt2 got %0d exp 2", cnt0); else passed++;
    enq(c, 0, 0);
    issue_ready = 1;
    step();
    total++; if (cnt0 !== 4'd2) $display("FAIL basic_cnt3 got %0d exp 2", cnt0); else passed++;
    total++; if (ii0 !== b) $display("FAIL basic_issue_b got %h exp %h", ii0, b); else passed++;
    enq_valid = 0;
    step();
    total++; if (cnt0 !== 4'd1) $display("FAIL basic_cnt4 got %0d exp 1", cnt0); else passed++;
    total++; if (ii0 !== c) $display("FAIL basic_issue_c got %h exp %h", ii0, c); else passed++;
    step();
    total++; if (cnt0 !== 4'd0) $display("FAIL basic_cnt5 got %0d exp 0", cnt0); else passed++;
    total++; if (iv0 !== 1'b0 || ii0 !== '0) $display("FAIL basic_empty got %b/%h exp 0/0", iv0, ii0); else passed++;
  endtask

  task automatic test_wakeup();
    queue_item_t w;
    w = mk(32'h200, 1, 5'd5, 0, 5'd0);
    do_reset();
    enq(w, 1, 0);
    step();
    enq_valid = 0;
    total++; if (iv0 !== 1'b0) $display("FAIL wake_blocked1 got %b exp 0", iv0); else passed++;
    step();
    total++; if (iv0 !== 1'b0) $display("FAIL wake_blocked2 got %b exp 0", iv0); else passed++;
    wb_valid = 2'b10;
    wb_rd = {5'd5, 5'd0};
    #1;
    total++; if (iv0 !== 1'b0) $display("FAIL wake_same_cycle got %b exp 0", iv0); else passed++;
    step();
    wb_valid = '0;
    total++; if (iv0 !== 1'b1 || ii0 !== w) $display("FAIL wake_next_cycle got %b/%h exp 1/%h", iv0, ii0, w); else passed++;
  endtask

  task automatic test_out_of_order();
    queue_item_t x, y, z;
    x = mk(32'h300, 0, 5'd0, 1, 5'd7);
    y = mk(32'h304, 1, 5'd8, 0, 5'd0);
    z = mk(32'h308, 0, 5'd0, 1, 5'd9);
    do_reset();
    enq(x, 0, 1);
    step();
    enq(y, 0, 0);
    step();
    enq(z, 0, 0);
    step();
    enq_valid = 0;
    total++; if (cnt0 !== 4'd3 || cnt1 !== 4'd3) $display("FAIL ooo_fill got %0d/%0d exp 3/3", cnt0, cnt1); else passed++;
    total++; if (ii0 !== y) $display("FAIL ooo_select_y got %h exp %h", ii0, y); else passed++;
    total++; if (iv1 !== 1'b0) $display("FAIL inord_blocked got %b exp 0", iv1); else passed++;
    issue_ready = 1;
    step();
    issue_ready = 0;
    total++; if (cnt0 !== 4'd2 || ii0 !== z) $display("FAIL ooo_collapse got %0d/%h exp 2/%h", cnt0, ii0, z); else passed++;
    total++; if (cnt1 !== 4'd3 || iv1 !== 1'b0) $display("FAIL inord_hold got %0d/%b exp 3/0", cnt1, iv1); else passed++;
    wb_valid = 2'b01;
    wb_rd = {5'd0, 5'd7};
    step();
    wb_valid = '0;
    total++; if (ii0 !== x) $display("FAIL ooo_oldest got %h exp %h", ii0, x); else passed++;
    total++; if (iv1 !== 1'b1 || ii1 !== x) $display("FAIL inord_woken got %b/%h exp 1/%h", iv1, ii1, x); else passed++;
    issue_ready = 1;
    step();
    issue_ready = 0;
    total++; if (cnt0 !== 4'd1 || ii0 !== z) $display("FAIL ooo_after got %0d/%h exp 1/%h", cnt0, ii0, z); else passed++;
    total++; if (cnt1 !== 4'd2 || ii1 !== y) $display("FAIL inord_after got %0d/%h exp 2/%h", cnt1, ii1, y); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      enq(mk(32'h400 + 32'(i), 0, 5'd0, 0, 5'd0), 0, 0);
      step();
    end
    total++; if (cnt0 !== 4'd8 || er0 !== 1'b0) $display("FAIL full_state got %0d/%b exp 8/0", cnt0, er0); else passed++;
    enq(mk(32'h499, 0, 5'd0, 0, 5'd0), 0, 0);
    step();
    total++; if (cnt0 !== 4'd8) $display("FAIL full_drop got %0d exp 8", cnt0); else passed++;
    issue_ready = 1;
    #1;
    total++; if (er0 !== 1'b0) $display("FAIL full_no_pass got %b exp 0", er0); else passed++;
    step();
    issue_ready = 0;
    enq_valid = 0;
    total++; if (cnt0 !== 4'd7 || er0 !== 1'b1) $display("FAIL full_release got %0d/%b exp 7/1", cnt0, er0); else passed++;
    total++; if (ii0.pc !== 32'h401) $display("FAIL full_next got %h exp 401", ii0.pc); else passed++;
  endtask

  task automatic test_x0();
    do_reset();
    enq(mk(32'h500, 1, 5'd0, 0, 5'd0), 1, 0);
    step();
    enq_valid = 0;
    total++; if (iv0 !== 1'b1) $display("FAIL x0_src_ready got %b exp 1", iv0); else passed++;
    do_reset();
    enq(mk(32'h504, 0, 5'd0, 1, 5'd3), 0, 1);
    step();
    enq_valid = 0;
    wb_valid = 2'b11;
    wb_rd = '0;
    step();
    step();
    wb_valid = '0;
    total++; if (iv0 !== 1'b0) $display("FAIL x0_no_wake got %b exp 0", iv0); else passed++;
    wb_valid = 2'b01;
    wb_rd = {5'd0, 5'd3};
    step();
    wb_valid = '0;
    total++; if (iv0 !== 1'b1) $display("FAIL r3_wake got %b exp 1", iv0); else passed++;
  endtask

  task automatic test_flush_rst();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      enq(mk(32'h600 + 32'(i), 0, 5'd0, 0, 5'd0), 0, 0);
      step();
    end
    total++; if (cnt0 !== 4'd5) $display("FAIL flush_pre got %0d exp 5", cnt0); else passed++;
    flush = 1;
    step();
    flush = 0;
    enq_valid = 0;
    total++; if (cnt0 !== 4'd0 || iv0 !== 1'b0) $display("FAIL flush_clear got %0d/%b exp 0/0", cnt0, iv0); else passed++;
    for (int i = 0; i < 2; i++) begin
      enq(mk(32'h700 + 32'(i), 0, 5'd0, 0, 5'd0), 0, 0);
      step();
    end
    enq_valid = 0;
    total++; if (cnt0 !== 4'd2 || iv0 !== 1'b1) $display("FAIL arst_pre got %0d/%b exp 2/1", cnt0, iv0); else passed++;
    #3;
    rst = 1;
    #1;
    total++; if (cnt0 !== 4'd0 || iv0 !== 1'b0) $display("FAIL arst_async got %0d/%b exp 0/0", cnt0, iv0); else passed++;
    total++; if (ii0 !== '0 || er0 !== 1'b1) $display("FAIL arst_outs got %h/%b exp 0/1", ii0, er0); else passed++;
    step();
    rst = 0;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_wakeup();
    test_out_of_order();
    test_full();
    test_x0();
    test_flush_rst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised collapsing issue queue holding `queue_item_t` entries between decode/dispatch and register-read. It tracks per-operand readiness via writeback wakeup broadcasts and selects one entry per cycle for issue. `IN_ORDER` selects head-only issue for the memory queue or oldest-ready issue for the ALU queue. One instance is built per `iqt::queue_type_t`.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; ≥2.
- `NUM_WB`, 2: writeback wakeup ports.
- `IN_ORDER`, 0: 1 = only entry 0 may issue; 0 = oldest ready entry issues.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: discard all entries (mispredict).
- `enq_valid` in 1: dispatch offers an item.
- `enq_ready` out 1: `count < DEPTH`; registered-count based only.
- `enq_item` in `queue_item_t`: item to enqueue.
- `enq_rs1_busy`, `enq_rs2_busy` in 1: scoreboard busy bits for the item's sources, sampled at enqueue.
- `wb_valid` in `NUM_WB`: writeback broadcast valid per port.
- `wb_rd` in `NUM_WB*5`: destination register per port; port k occupies bits [5k+4:5k].
- `issue_valid` out 1: a selected entry is ready.
- `issue_ready` in 1: register-read accepts the issue.
- `issue_item` out `queue_item_t`: selected entry; zero when `issue_valid`=0.
- `count` out `$clog2(DEPTH+1)`: occupied entries.

## Operation
- Storage: `DEPTH` slots, each holding `valid`, `item`, `rs1_rdy` and `rs2_rdy`. Slot 0 is the oldest entry. Valid slots are always contiguous from slot 0.
- Enqueue readiness, per source s:
  - `rdy = !has_rs || rs==0 || !busy || wake_hit(rs)`.
  - `wake_hit(r)`: any k with `wb_valid[k] && wb_rd[k]==r && r!=0`.
- Wakeup: every cycle, each valid entry ORs `wake_hit(rs1)` into `rs1_rdy` and `wake_hit(rs2)` into `rs2_rdy`. Register x0 never wakes or blocks.
- Entry ready = `valid && rs1_rdy && rs2_rdy`, using registered state only. Same-cycle wakeup does not make an entry issue-eligible until the next cycle.
- Select:
  - `IN_ORDER=1`: slot 0 only.
  - `IN_ORDER=0`: lowest-index ready slot (priority encoder).
- Issue fire = `issue_valid && issue_ready`. The selected slot is removed. Slots above it shift down by one, carrying their updated readiness including same-cycle wakeups.
- Enqueue fire = `enq_valid && enq_ready && !flush`. The item is written to slot `count`, or to `count-1` if an issue fires in the same cycle.
- `count` next value = `count + enq_fire - issue_fire`.
- Flush: all `valid` bits clear next cycle and `count` becomes 0. Flush overrides both same-cycle enqueue and issue state updates. An issue handshake in the flush cycle is still presented on the outputs; the consumer is responsible for squashing it.
- An item with `has_rd=0` is not special-cased. Scoreboard set/clear is outside this block.

## Timing
- Reset (async assert): all `valid`=0, `count`=0, `issue_valid`=0, `issue_item`=0, `enq_ready`=1. State is held until the first edge after deassertion.
- Minimum latency is enqueue at edge N to `issue_valid` from edge N (i.e. the next cycle), when the item is ready at enqueue.
- Wakeup-to-issue is one cycle: broadcast in cycle N, entry is eligible in cycle N+1.
- Full (`count==DEPTH`): `enq_ready`=0 even if an issue fires in the same cycle (no pass-through).
- Empty: `issue_valid`=0. An enqueue into an empty queue never issues in the same cycle.
- Enqueue and issue in the same cycle keep `count` unchanged, and ordering is preserved.
- `issue_valid` and `issue_item` are combinational from registered state. They must not depend on `issue_ready` (no combinational loop).
- `rst` asserted mid-operation clears state immediately, independent of `clk`.

## Test plan
- Reset then `IN_ORDER=0`: enqueue 3 ready items A, B, C with `issue_ready`=1 → issue A, B, C on consecutive cycles; `count` goes 1, 2, 2, 1, 0 as expected.
- `enq_rs1_busy`=1 for an item with rs1=5, then `wb_valid[1]`=1, `wb_rd`=5 two cycles later → `issue_valid` rises exactly one cycle after the broadcast.
- `IN_ORDER=0`: slot 0 blocked (rs2=7 busy), slot 1 ready → slot 1 issues first and slot 2 collapses to slot 1. The same stimulus with `IN_ORDER=1` → nothing issues until r7 wakes.
- Fill to `DEPTH`=8 with `issue_ready`=0 → `enq_ready`=0 and a ninth enqueue is dropped. Then issue one → `enq_ready`=1 on the next cycle and `count`=7.
- Busy source with rs1=0 → ready at enqueue. A `wb_rd`=0 broadcast never wakes an entry waiting on rs2=3.
- Queue at count 5; `flush` asserted together with `enq_valid`=1 → `count`=0 and `issue_valid`=0 next cycle. Async `rst` pulse mid-cycle → outputs return to reset values before the next edge.
